fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-domain pointer source for the asynchronous FIFO: the sending end of the gray-pointer crossing whose receiving end is the two-flop pointer synchronizer.
- Maintains the binary write address and a registered gray write pointer; only the gray pointer is exported to the read domain.
- Generates the full flag against the read pointer after it has been synchronized into this domain.
- Sits between the FIFO write interface and the dual-port RAM write port.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.
- AFULL_MARGIN, 2, free-slot threshold for almost_full (used only with ALMOST_FULL_EN).

Ports:
- clk  input  1  write-domain clock
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  write request from producer
- rptr_sync  input  ADDR_W+1  gray read pointer, already synchronized into clk domain
- waddr  output  ADDR_W  RAM write address (binary)
- wptr  output  ADDR_W+1  registered gray write pointer, to read-domain synchronizer
- wr_accept  output  1  combinational: wr_en & ~full; RAM write strobe
- full  output  1  registered full flag
- overflow  output  1  registered one-cycle pulse: write attempted while full
- almost_full  output  1  registered (ALMOST_FULL_EN only)

Behaviour:
- Reset (async, rst=1): wbin=0, wptr=0, waddr=0, full=0, overflow=0, almost_full=0. Outputs hold reset values while rst=1.
- Internal wbin is ADDR_W+1 bits. waddr = wbin[ADDR_W-1:0].
- wbin_next = wbin + wr_accept, wrapping modulo 2**(ADDR_W+1). wgray_next = (wbin_next>>1) ^ wbin_next.
- Every edge: wbin<=wbin_next; wptr<=wgray_next. wptr is driven directly from a flop: no combinational logic after the register, only one bit changes per increment.
- Full rule: full <= (wgray_next == {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]}).
  - The 16th accepted write after empty (ADDR_W=4) asserts full on the same edge that updates wptr.
- full deasserts on the first edge after rptr_sync advances. Extra latency from the synchronizer stages is pessimistic and allowed.
- Write while full: not accepted; wbin, wptr and waddr are unchanged; overflow=1 for exactly one cycle per offending cycle (overflow <= wr_en & full).
- Simultaneous write and rptr_sync change: compare uses the new rptr_sync and wgray_next. No write is lost or duplicated.
- Wrap-around: after 2**(ADDR_W+1) accepted writes, wbin returns to 0 and the MSB toggle pattern repeats. Full detection stays correct across the wrap.
- Reset mid-operation: all state clears immediately, without waiting for a clock. The read side must be reset concurrently.
- Exported gray values are only 0, or successors of the previous value differing in exactly one bit.

Optional Feature:
- Macro: FIFO_WPTR_ALMOST_FULL_EN.
- Defined:
  - rptr_sync is converted gray->binary to rbin.
  - used = wbin_next - rbin, computed modulo 2**(ADDR_W+1).
  - almost_full <= (used >= 2**ADDR_W - AFULL_MARGIN); it also stays 1 while full.
- Undefined: port almost_full still exists, tied to 0; no gray->binary logic is synthesized.

Decomposition:
- Package fifo_cdc_pkg:
  - functions bin2gray and gray2bin, parameterized by width;
  - localparam DEFAULT_ADDR_W=4.
  - Shared with the read-pointer/empty block.
- Sub-module: none required. The gray->binary conversion is a package function, not a separate instance.

Test Plan:
- Reset with wr_en=1 held -> after deassert waddr=0, wptr=5'b00000, full=0. First edge with wr_en=1 -> waddr=1, wptr=5'b00001.
- rptr_sync=0, 16 consecutive writes (ADDR_W=4) -> wptr sequence 0,1,3,2,6,... ends at 5'b11000; full=1 on the 16th edge; 17th wr_en -> overflow=1 for one cycle, waddr stays 0.
- From full: set rptr_sync=5'b00001 -> full=0 next edge. One write -> wptr=5'b11001, full=1 again.
- Run 40 writes interleaved with read-pointer advances -> wbin wraps past 31 to 0; full never falsely asserts or deasserts; every wptr transition changes exactly 1 bit (checker).
- Assert rst mid-burst (waddr=7) between clock edges -> outputs zero immediately, before the next edge; post-reset writes resume from waddr=0.
- With FIFO_WPTR_ALMOST_FULL_EN and AFULL_MARGIN=2: rptr_sync=0, 14 writes -> almost_full=1 on the 14th edge, full=0; 2 more writes -> full=1, almost_full=1.

Source files
------------

// File: rtl/fifo_cdc_pkg.sv
// ============================================================================
// Module : fifo_cdc_pkg
// Brief  : Shared gray/binary pointer helpers for the async FIFO pointer blocks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_cdc_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int CONV_W         = 32;

    // Width-generic: callers zero-extend into CONV_W bits and cast the result back
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
// ============================================================================
// Module : fifo_wptr_full
// Brief  : Write-domain pointer and full flag for the async FIFO.
//          Optional almost_full via `define FIFO_WPTR_ALMOST_FULL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_wptr_full
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int AFULL_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_sync,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wr_accept,
    output logic              full,
    output logic              overflow,
    output logic              almost_full
);

    localparam int PW = ADDR_W + 1;

    if (ADDR_W < 2 || AFULL_MARGIN < 0 || AFULL_MARGIN > (2 ** ADDR_W)) begin : g_param_check
        $error("fifo_wptr_full: ADDR_W must be >= 2 and AFULL_MARGIN within 0..depth");
    end

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wgray_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;

    assign wr_accept  = wr_en & ~full_q;
    assign wbin_d     = wbin_q + PW'(wr_accept);
    assign wgray_d    = PW'(bin2gray(CONV_W'(wbin_d)));
    // Full when the write pointer is exactly one lap ahead: top two gray bits inverted
    assign full_d     = (wgray_d == {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]});
    assign overflow_d = wr_en & full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wgray_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign waddr    = wbin_q[ADDR_W-1:0];
    assign wptr     = wptr_q;
    assign full     = full_q;
    assign overflow = overflow_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] used;
    logic          afull_d, afull_q;

    assign rbin    = PW'(gray2bin(CONV_W'(rptr_sync)));
    assign used    = wbin_d - rbin;
    assign afull_d = (used >= PW'((2 ** ADDR_W) - AFULL_MARGIN)) | full_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign almost_full = afull_q;
`else
    assign almost_full = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
// ============================================================================
// Module : tb_fifo_wptr_full
// Brief  : Self-checking bench for fifo_wptr_full against an occupancy model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_wptr_full;

    localparam int AW     = 4;
    localparam int PW     = AW + 1;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [PW-1:0] rptr_sync = '0;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wr_accept;
    logic          full;
    logic          overflow;
    logic          almost_full;

    fifo_wptr_full #(.ADDR_W(AW), .AFULL_MARGIN(MARGIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rptr_sync   (rptr_sync),
        .waddr       (waddr),
        .wptr        (wptr),
        .wr_accept   (wr_accept),
        .full        (full),
        .overflow    (overflow),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            wcnt   = 0;   // total accepted writes since reset
    int            rcnt   = 0;   // total reads seen via rptr_sync since reset
    bit            full_m = 1'b0;
    bit            ovf_m  = 1'b0;
    logic [PW-1:0] prev_wptr = '0;

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    function automatic bit afull_exp();
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        return (wcnt - rcnt) >= (DEPTH - MARGIN);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("waddr",    32'(waddr),       32'(wcnt % DEPTH));
        check("wptr",     32'(wptr),        32'(gray(wcnt)));
        check("full",     32'(full),        32'(full_m));
        check("overflow", 32'(overflow),    32'(ovf_m));
        check("afull",    32'(almost_full), 32'(afull_exp()));
        if (wptr !== prev_wptr)
            check("wptr_1bit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
        prev_wptr = wptr;
    endtask

    task automatic model_clear();
        wcnt = 0; rcnt = 0; full_m = 1'b0; ovf_m = 1'b0; prev_wptr = '0;
    endtask

    // One clock: apply inputs, check the write strobe, then the registered outputs
    task automatic step(input bit we, input bit rd);
        wr_en = we;
        if (rd && rcnt < wcnt) rcnt++;
        rptr_sync = gray(rcnt);
        #1;
        check("wr_accept", 32'(wr_accept), 32'(we && !full_m));
        @(posedge clk);
        #1;
        ovf_m = we && full_m;
        if (we && !full_m) wcnt++;
        full_m = ((wcnt - rcnt) == DEPTH);
        check_outputs();
    endtask

    initial begin
        // Reset held with wr_en asserted
        rst = 1'b1; wr_en = 1'b1; rptr_sync = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        #3 rst = 1'b0;
        #1;
        check_outputs();
        step(1'b1, 1'b0);
        check("first_waddr", 32'(waddr), 32'd1);
        check("first_wptr",  32'(wptr),  32'b00001);

        // Fill to full from empty (15 more writes)
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        check("wptr_at_full", 32'(wptr), 32'b11000);
        check("full_at_16",   32'(full), 32'd1);
        step(1'b1, 1'b0);
        check("ovf_pulse",    32'(overflow), 32'd1);
        check("waddr_held",   32'(waddr),    32'd0);
        step(1'b0, 1'b0);
        check("ovf_single",   32'(overflow), 32'd0);

        // Release one slot, then refill it
        step(1'b0, 1'b1);
        check("full_release", 32'(full), 32'd0);
        step(1'b1, 1'b0);
        check("wptr_refill",  32'(wptr), 32'b11001);
        check("full_again",   32'(full), 32'd1);

        // Random writes and read-pointer advances, crossing the pointer wrap
        for (int i = 0; i < 120; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

        // Asynchronous reset mid-burst at waddr=7
        rst = 1'b1; rptr_sync = '0; wr_en = 1'b0;
        model_clear();
        @(posedge clk); #4 rst = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        check("waddr_7", 32'(waddr), 32'd7);
        #3;
        rst = 1'b1; rptr_sync = '0;
        model_clear();
        #1;
        check("async_waddr", 32'(waddr), 32'd0);
        check("async_wptr",  32'(wptr),  32'd0);
        check("async_full",  32'(full),  32'd0);
        @(posedge clk); #4 rst = 1'b0;
        step(1'b1, 1'b0);
        check("resume_waddr", 32'(waddr), 32'd1);

        // Almost-full threshold from empty
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        check("afull_at_14", 32'(almost_full), 32'd1);
`else
        check("afull_tied0", 32'(almost_full), 32'd0);
`endif
        check("not_full_14", 32'(full), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("full_at_16b", 32'(full), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
